// File: rtl/adder_pipe.sv
// Pipelined BITS-wide unsigned adder: one CW=BITS/LEVEL chunk per stage, carry rippled through registers, LEVEL cycles latency.
// Define ADDER_PIPE_SKID_EN to add a 1-entry output skid so i_add_rdy is registered instead of combinational from o_add_rdy.
module adder_pipe #(
  parameter int BITS     = 768,
  parameter int CTL_BITS = 8,
  parameter int LEVEL    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_add_val,
  output logic                  i_add_rdy,
  input  logic [2*BITS-1:0]     i_add_dat,
  input  logic                  i_add_sop,
  input  logic                  i_add_eop,
  input  logic [CTL_BITS-1:0]   i_add_ctl,
  output logic                  o_add_val,
  input  logic                  o_add_rdy,
  output logic [BITS:0]         o_add_dat,
  output logic                  o_add_sop,
  output logic                  o_add_eop,
  output logic [CTL_BITS-1:0]   o_add_ctl
);

  localparam int CW = BITS / LEVEL;

  if (LEVEL < 1 || (BITS % LEVEL) != 0) begin : g_param_check
    $fatal(1, "adder_pipe: BITS must be divisible by LEVEL and LEVEL >= 1");
  end

  logic [LEVEL-1:0]    val_q, sop_q, eop_q, carry_q, ld;
  logic [CTL_BITS-1:0] ctl_q [LEVEL];
  logic [BITS-1:0]     sum_q [LEVEL];
  logic [BITS-1:0]     a_q   [LEVEL];
  logic [BITS-1:0]     b_q   [LEVEL];

  logic [LEVEL-1:0]    val_in, sop_in, eop_in, c_in, carry_d;
  logic [CTL_BITS-1:0] ctl_in [LEVEL];
  logic [BITS-1:0]     s_in   [LEVEL];
  logic [BITS-1:0]     a_in   [LEVEL];
  logic [BITS-1:0]     b_in   [LEVEL];
  logic [BITS-1:0]     sum_d  [LEVEL];
  logic [BITS-1:0]     a_d    [LEVEL];
  logic [BITS-1:0]     b_d    [LEVEL];

  // a/b are kept right-aligned: the chunk a stage consumes always sits at [CW-1:0]
  always_comb begin
    val_in    = '0;
    sop_in    = '0;
    eop_in    = '0;
    c_in      = '0;
    carry_d   = '0;
    val_in[0] = i_add_val;
    sop_in[0] = i_add_sop;
    eop_in[0] = i_add_eop;
    ctl_in[0] = i_add_ctl;
    s_in[0]   = '0;
    a_in[0]   = i_add_dat[0 +: BITS];
    b_in[0]   = i_add_dat[BITS +: BITS];
    for (int k = 1; k < LEVEL; k++) begin
      val_in[k] = val_q[k-1];
      sop_in[k] = sop_q[k-1];
      eop_in[k] = eop_q[k-1];
      c_in[k]   = carry_q[k-1];
      ctl_in[k] = ctl_q[k-1];
      s_in[k]   = sum_q[k-1];
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
    end
    for (int k = 0; k < LEVEL; k++) begin
      sum_d[k] = s_in[k];
      {carry_d[k], sum_d[k][k*CW +: CW]} = {1'b0, a_in[k][CW-1:0]}
                                         + {1'b0, b_in[k][CW-1:0]}
                                         + {{CW{1'b0}}, c_in[k]};
      a_d[k] = a_in[k] >> CW;
      b_d[k] = b_in[k] >> CW;
    end
  end

`ifdef ADDER_PIPE_SKID_EN
  logic                skid_full_q;
  logic [BITS:0]       skid_dat_q;
  logic                skid_sop_q, skid_eop_q;
  logic [CTL_BITS-1:0] skid_ctl_q;

  always_comb begin
    ld = '0;
    for (int k = 0; k < LEVEL; k++) ld[k] = ~skid_full_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      skid_full_q <= 1'b0;
      skid_dat_q  <= '0;
      skid_sop_q  <= 1'b0;
      skid_eop_q  <= 1'b0;
      skid_ctl_q  <= '0;
    end else if (skid_full_q) begin
      if (o_add_rdy) skid_full_q <= 1'b0;
    end else if (val_q[LEVEL-1] && !o_add_rdy) begin
      skid_full_q <= 1'b1;
      skid_dat_q  <= {carry_q[LEVEL-1], sum_q[LEVEL-1]};
      skid_sop_q  <= sop_q[LEVEL-1];
      skid_eop_q  <= eop_q[LEVEL-1];
      skid_ctl_q  <= ctl_q[LEVEL-1];
    end
  end

  assign i_add_rdy = ~skid_full_q;
  assign o_add_val = skid_full_q | val_q[LEVEL-1];
  assign o_add_dat = skid_full_q ? skid_dat_q : {carry_q[LEVEL-1], sum_q[LEVEL-1]};
  assign o_add_sop = skid_full_q ? skid_sop_q : sop_q[LEVEL-1];
  assign o_add_eop = skid_full_q ? skid_eop_q : eop_q[LEVEL-1];
  assign o_add_ctl = skid_full_q ? skid_ctl_q : ctl_q[LEVEL-1];
`else
  // An empty stage always loads, so bubbles collapse under a downstream stall
  always_comb begin
    ld = '0;
    ld[LEVEL-1] = ~val_q[LEVEL-1] | o_add_rdy;
    for (int k = LEVEL-2; k >= 0; k--) ld[k] = ~val_q[k] | ld[k+1];
  end

  assign i_add_rdy = ld[0];
  assign o_add_val = val_q[LEVEL-1];
  assign o_add_dat = {carry_q[LEVEL-1], sum_q[LEVEL-1]};
  assign o_add_sop = sop_q[LEVEL-1];
  assign o_add_eop = eop_q[LEVEL-1];
  assign o_add_ctl = ctl_q[LEVEL-1];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      val_q   <= '0;
      sop_q   <= '0;
      eop_q   <= '0;
      carry_q <= '0;
      for (int k = 0; k < LEVEL; k++) begin
        ctl_q[k] <= '0;
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < LEVEL; k++) begin
        if (ld[k]) begin
          val_q[k]   <= val_in[k];
          sop_q[k]   <= sop_in[k];
          eop_q[k]   <= eop_in[k];
          carry_q[k] <= carry_d[k];
          ctl_q[k]   <= ctl_in[k];
          sum_q[k]   <= sum_d[k];
          a_q[k]     <= a_d[k];
          b_q[k]     <= b_d[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Randomized and directed bench for adder_pipe (BITS=8, LEVEL=2) against a queue-based a+b reference model.
module tb_adder_pipe;
  localparam int BITS  = 8;
  localparam int CTL   = 8;
  localparam int LEVEL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              i_rst;
  logic              i_add_val, i_add_rdy, i_add_sop, i_add_eop;
  logic [2*BITS-1:0] i_add_dat;
  logic [CTL-1:0]    i_add_ctl;
  logic              o_add_val, o_add_rdy, o_add_sop, o_add_eop;
  logic [BITS:0]     o_add_dat;
  logic [CTL-1:0]    o_add_ctl;

  adder_pipe #(.BITS(BITS), .CTL_BITS(CTL), .LEVEL(LEVEL)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_add_val(i_add_val), .i_add_rdy(i_add_rdy), .i_add_dat(i_add_dat),
    .i_add_sop(i_add_sop), .i_add_eop(i_add_eop), .i_add_ctl(i_add_ctl),
    .o_add_val(o_add_val), .o_add_rdy(o_add_rdy), .o_add_dat(o_add_dat),
    .o_add_sop(o_add_sop), .o_add_eop(o_add_eop), .o_add_ctl(o_add_ctl)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_out   = 0;
  int cycle   = 0;
  logic [18:0] exp_q [$];
  int          out_cyc [$];
  logic        hold_prev = 1'b0;
  logic [18:0] held;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] out_word();
    return {o_add_sop, o_add_eop, o_add_ctl, o_add_dat};
  endfunction

  // one clock: observe handshakes at negedge, return #1 after posedge
  task automatic step();
    logic [8:0] s;
    @(negedge clk);
    if (i_rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) chk("hold_stable", out_word(), held);
      if (i_add_val && i_add_rdy) begin
        s = {1'b0, i_add_dat[7:0]} + {1'b0, i_add_dat[15:8]};
        exp_q.push_back({i_add_sop, i_add_eop, i_add_ctl, s});
        n_acc++;
      end
      if (o_add_val && o_add_rdy) begin
        if (exp_q.size() == 0) chk("spurious_out", o_add_val, 0);
        else chk("out_word", out_word(), exp_q.pop_front());
        n_out++;
        out_cyc.push_back(cycle);
      end
      hold_prev = o_add_val && !o_add_rdy;
      held      = out_word();
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic randomize_in();
    i_add_dat = 16'($urandom);
    i_add_ctl = 8'($urandom);
    i_add_sop = 1'($urandom);
    i_add_eop = 1'($urandom);
  endtask

  task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ctl, input logic sop, input logic eop,
                          input logic [8:0] exp_dat);
    int n;
    int acc0;
    acc0 = n_acc;
    o_add_rdy = 1'b1;
    i_add_val = 1'b1;
    i_add_dat = {b, a};
    i_add_ctl = ctl;
    i_add_sop = sop;
    i_add_eop = eop;
    step();
    chk({tag, "_accept"}, n_acc - acc0, 1);
    i_add_val = 1'b0;
    randomize_in();
    n = 0;
    while (!o_add_val && n < 8) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, LEVEL - 1);
    chk({tag, "_dat"}, o_add_dat, exp_dat);
    chk({tag, "_side"}, {o_add_sop, o_add_eop, o_add_ctl}, {sop, eop, ctl});
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, out0, budget;
    i_rst = 1'b1; i_add_val = 1'b1; o_add_rdy = 1'b1;
    randomize_in();

    // reset held 3 cycles with input valid
    repeat (3) begin
      step();
      chk("rst_val", o_add_val, 0);
      chk("rst_dat", o_add_dat, 0);
      chk("rst_side", {o_add_sop, o_add_eop, o_add_ctl}, 0);
    end
    i_rst = 1'b0; i_add_val = 1'b0;
    repeat (4) step();
    chk("rst_no_output", n_out, 0);

    directed("carry_chunk", 8'h0F, 8'h01, 8'h5A, 1'b1, 1'b0, 9'h010);
    directed("carry_out_ff", 8'hFF, 8'hFF, 8'hA5, 1'b0, 1'b1, 9'h1FE);
    directed("carry_out_01", 8'hFF, 8'h01, 8'h3C, 1'b1, 1'b1, 9'h100);

    // back-to-back throughput
    acc0 = n_acc; out0 = n_out;
    out_cyc.delete();
    o_add_rdy = 1'b1;
    for (int i = 0; i < 64; i++) begin
      i_add_val = 1'b1;
      randomize_in();
      step();
    end
    i_add_val = 1'b0;
    repeat (6) step();
    chk("tput_accepts", n_acc - acc0, 64);
    chk("tput_outputs", n_out - out0, 64);
    chk("tput_span", (out_cyc.size() == 64) ? out_cyc[63] - out_cyc[0] : -1, 63);

    // random valid/ready
    acc0 = n_acc; out0 = n_out; budget = 0;
    while (n_acc - acc0 < 1000 && budget < 20000) begin
      i_add_val = 1'($urandom);
      o_add_rdy = 1'($urandom);
      randomize_in();
      step();
      budget++;
    end
    i_add_val = 1'b0;
    o_add_rdy = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      step();
      budget++;
    end
    repeat (3) step();
    chk("bp_accepts", n_acc - acc0, 1000);
    chk("bp_outputs", n_out - out0, 1000);
    chk("bp_drained", exp_q.size(), 0);

    // reset with items in flight
    o_add_rdy = 1'b0;
    i_add_val = 1'b1;
    randomize_in();
    step();
    randomize_in();
    step();
    i_add_val = 1'b0;
    step();
    chk("mid_stalled_val", o_add_val, 1);
    i_rst = 1'b1;
    step();
    chk("mid_rst_val", o_add_val, 0);
    i_rst = 1'b0;
    o_add_rdy = 1'b1;
    out0 = n_out;
    repeat (4) step();
    chk("mid_no_output", n_out - out0, 0);
    directed("after_rst", 8'h03, 8'h04, 8'h11, 1'b1, 1'b0, 9'h007);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
